bin2bcd_seq: RTL and testbench

Sequential, parametrised binary-to-BCD converter. It uses iterative double-dabble with one shift step per clock and a start/done handshake, so a W-bit conversion costs W cycles of a single D-digit add-3/shift datapath. It replaces the unrolled combinational converter chain in display paths where the binary width varies or exceeds 11 bits. It also produces a leading-zero blanking mask for the seven-segment driver.

---
 rtl/bin2bcd_seq.sv | 134 +++++++++++++
 tb/tb_bin2bcd_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one add-3/shift step per clock,
// start/done handshake, and a leading-zero blanking mask for the display driver.
module bin2bcd_seq #(
   parameter int unsigned W = 11,
   parameter int unsigned D = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [W-1:0]     in,
   output logic             busy,
   output logic             done,
   output logic [4*D-1:0]   out,
   output logic [D-1:0]     digit_en
);

   localparam int unsigned CW = $clog2(W + 1);
   localparam int unsigned SW = 4 * D;

   typedef enum logic {IDLE, SHIFT} state_e;

   state_e          state_q, state_d;
   logic [W-1:0]    sr_q, sr_d;
   logic [SW-1:0]   scr_q, scr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [SW-1:0]   out_q, out_d;
   logic [D-1:0]    en_q, en_d;

   logic [SW-1:0]   adj_c;
   logic [SW+W-1:0] shifted_c;
   logic            last_c;
   logic [D-1:0]    en_new_c;

   // Parallel add-3 on every scratch digit, then one left shift of {scratch, binary}
   always_comb begin
      logic [3:0] dig;
      adj_c = '0;
      dig   = '0;
      for (int i = 0; i < int'(D); i++) begin
         dig = scr_q[4*i +: 4];
         adj_c[4*i +: 4] = (dig >= 4'd5) ? dig + 4'd3 : dig;
      end
      shifted_c = {adj_c, sr_q} << 1;
      last_c    = (cnt_q == CW'(1));
   end

   // Digit i is shown if it or any more significant digit of the new result is nonzero
   always_comb begin
      logic nz;
      nz       = 1'b0;
      en_new_c = '0;
      for (int i = int'(D) - 1; i >= 1; i--) begin
         nz          = nz | (shifted_c[W + 4*i +: 4] != 4'd0);
         en_new_c[i] = nz;
      end
      en_new_c[0] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start)  state_d = SHIFT;
         SHIFT:   if (last_c) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      sr_d   = sr_q;
      scr_d  = scr_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      done_d = 1'b0;
      out_d  = out_q;
      en_d   = en_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               sr_d   = in;
               scr_d  = '0;
               cnt_d  = CW'(W);
               busy_d = 1'b1;
            end
         end
         SHIFT: begin
            scr_d = shifted_c[SW+W-1:W];
            sr_d  = shifted_c[W-1:0];
            cnt_d = cnt_q - CW'(1);
            if (last_c) begin
               out_d  = shifted_c[SW+W-1:W];
               en_d   = en_new_c;
               done_d = 1'b1;
               busy_d = 1'b0;
            end
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_q   <= '0;
         scr_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         out_q  <= '0;
         en_q   <= D'(1);
      end else begin
         sr_q   <= sr_d;
         scr_q  <= scr_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
         out_q  <= out_d;
         en_q   <= en_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign out      = out_q;
   assign digit_en = en_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: three configurations checked every cycle against a decimal
// arithmetic model, plus literal expectations from hand-worked conversions.
module tb_bin2bcd_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  st;
   logic [10:0] in_a;
   logic [15:0] in_b;
   logic [7:0]  in_c;
   logic        busy_a, busy_b, busy_c;
   logic        done_a, done_b, done_c;
   logic [15:0] out_a;
   logic [19:0] out_b;
   logic [7:0]  out_c;
   logic [3:0]  en_a;
   logic [4:0]  en_b;
   logic [1:0]  en_c;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bin2bcd_seq #(.W(11), .D(4)) u_a (.clk(clk), .rst(rst), .start(st[0]), .in(in_a),
      .busy(busy_a), .done(done_a), .out(out_a), .digit_en(en_a));
   bin2bcd_seq #(.W(16), .D(5)) u_b (.clk(clk), .rst(rst), .start(st[1]), .in(in_b),
      .busy(busy_b), .done(done_b), .out(out_b), .digit_en(en_b));
   bin2bcd_seq #(.W(8), .D(2)) u_c (.clk(clk), .rst(rst), .start(st[2]), .in(in_c),
      .busy(busy_c), .done(done_c), .out(out_c), .digit_en(en_c));

   function automatic int wv(input int n);
      return (n == 0) ? 11 : ((n == 1) ? 16 : 8);
   endfunction

   function automatic int dv(input int n);
      return (n == 0) ? 4 : ((n == 1) ? 5 : 2);
   endfunction

   // Decimal digits of v, keeping only the lowest d (i.e. v mod 10^d)
   function automatic logic [31:0] to_bcd(input longint unsigned v, input int d);
      logic [31:0] r;
      longint unsigned x;
      r = '0;
      x = v;
      for (int i = 0; i < d; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [7:0] en_of(input logic [31:0] r, input int d);
      logic [7:0] e;
      e = '0;
      e[0] = 1'b1;
      for (int i = 1; i < d; i++) e[i] = ((r >> (4*i)) != 32'd0);
      return e;
   endfunction

   function automatic logic [15:0] in_of(input int n);
      case (n)
         0:       return 16'(in_a);
         1:       return in_b;
         default: return 16'(in_c);
      endcase
   endfunction

   function automatic logic get_busy(input int n);
      case (n)
         0:       return busy_a;
         1:       return busy_b;
         default: return busy_c;
      endcase
   endfunction

   function automatic logic get_done(input int n);
      case (n)
         0:       return done_a;
         1:       return done_b;
         default: return done_c;
      endcase
   endfunction

   function automatic logic [31:0] get_out(input int n);
      case (n)
         0:       return 32'(out_a);
         1:       return 32'(out_b);
         default: return 32'(out_c);
      endcase
   endfunction

   function automatic logic [7:0] get_en(input int n);
      case (n)
         0:       return 8'(en_a);
         1:       return 8'(en_b);
         default: return 8'(en_c);
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: a conversion accepted at cycle c produces its decimal result at cycle c+W
   longint      cyc = 0;
   logic        m_busy [3];
   logic        m_done [3];
   longint      m_val  [3];
   longint      m_due  [3];
   logic [31:0] m_out  [3];
   logic [7:0]  m_en   [3];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int n = 0; n < 3; n++) begin
            m_busy[n] <= 1'b0;
            m_done[n] <= 1'b0;
            m_out[n]  <= '0;
            m_en[n]   <= 8'd1;
            m_val[n]  <= 0;
            m_due[n]  <= 0;
         end
      end else begin
         cyc <= cyc + 1;
         for (int n = 0; n < 3; n++) begin
            m_done[n] <= 1'b0;
            if (m_busy[n]) begin
               if (cyc == m_due[n]) begin
                  m_busy[n] <= 1'b0;
                  m_done[n] <= 1'b1;
                  m_out[n]  <= to_bcd(longint'(m_val[n]), dv(n));
                  m_en[n]   <= en_of(to_bcd(longint'(m_val[n]), dv(n)), dv(n));
               end
            end else if (st[n]) begin
               m_busy[n] <= 1'b1;
               m_val[n]  <= longint'(in_of(n));
               m_due[n]  <= cyc + longint'(wv(n));
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int n = 0; n < 3; n++) begin
         chk($sformatf("busy[%0d]", n), 32'(get_busy(n)), 32'(m_busy[n]));
         chk($sformatf("done[%0d]", n), 32'(get_done(n)), 32'(m_done[n]));
         chk($sformatf("out[%0d]", n), get_out(n), m_out[n]);
         chk($sformatf("digit_en[%0d]", n), 32'(get_en(n)), 32'(m_en[n]));
         chk($sformatf("busy_and_done[%0d]", n), 32'(get_busy(n) & get_done(n)), 32'd0);
      end
   end

   task automatic set_in(input int n, input longint v);
      case (n)
         0:       in_a = 11'(v);
         1:       in_b = 16'(v);
         default: in_c = 8'(v);
      endcase
   endtask

   task automatic wait_done(input int n, inout int lat, inout int bcnt);
      while (!get_done(n) && lat < 60) begin
         @(negedge clk);
         lat++;
         if (get_busy(n)) bcnt++;
      end
      if (!get_done(n)) chk($sformatf("done_timeout[%0d]", n), 32'd0, 32'd1);
   endtask

   // Pulse start for one cycle, then wait (bounded) for done; ends on the done cycle
   task automatic run(input int n, input longint v, output int lat, output int bcnt);
      @(negedge clk);
      set_in(n, v);
      st[n] = 1'b1;
      @(negedge clk);
      st[n] = 1'b0;
      lat  = 0;
      bcnt = get_busy(n) ? 1 : 0;
      wait_done(n, lat, bcnt);
   endtask

   initial begin
      int lat, bcnt, seen;
      longint v;
      st = '0; in_a = '0; in_b = '0; in_c = '0;
      rst = 1'b0;
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_out", 32'(out_a), 32'h0);
      chk("reset_en", 32'(en_a), 32'h1);
      chk("reset_busy", 32'(busy_a), 32'h0);
      rst = 1'b0;

      run(0, 2047, lat, bcnt);
      chk("lat_2047", 32'(lat), 32'd11);
      chk("busy_cycles_2047", 32'(bcnt), 32'd11);
      chk("out_2047", 32'(out_a), 32'h2047);
      chk("en_2047", 32'(en_a), 32'hF);

      run(0, 0, lat, bcnt);
      chk("out_0", 32'(out_a), 32'h0000);
      chk("en_0", 32'(en_a), 32'h1);
      run(0, 5, lat, bcnt);
      chk("out_5", 32'(out_a), 32'h0005);
      chk("en_5", 32'(en_a), 32'h1);
      run(0, 1000, lat, bcnt);
      chk("out_1000", 32'(out_a), 32'h1000);
      chk("en_1000", 32'(en_a), 32'hF);
      run(0, 999, lat, bcnt);
      chk("out_999", 32'(out_a), 32'h0999);
      chk("en_999", 32'(en_a), 32'h7);

      // start while busy must be ignored
      @(negedge clk);
      in_a = 11'd123; st[0] = 1'b1;
      @(negedge clk);
      st[0] = 1'b0;
      repeat (3) @(negedge clk);
      in_a = 11'd456; st[0] = 1'b1;
      @(negedge clk);
      st[0] = 1'b0;
      lat = 0; bcnt = 0;
      wait_done(0, lat, bcnt);
      chk("out_ignored_start", 32'(out_a), 32'h0123);

      // start held in the done cycle is accepted; next done W+1 cycles later
      in_a = 11'd456; st[0] = 1'b1;
      @(negedge clk);
      st[0] = 1'b0;
      lat = 1; bcnt = 0;
      wait_done(0, lat, bcnt);
      chk("b2b_spacing", 32'(lat), 32'd12);
      chk("out_b2b", 32'(out_a), 32'h0456);

      // reset in the middle of a conversion
      run(0, 2047, lat, bcnt);
      @(negedge clk);
      in_a = 11'd1500; st[0] = 1'b1;
      @(negedge clk);
      st[0] = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_mid_out", 32'(out_a), 32'h0);
      chk("rst_mid_busy", 32'(busy_a), 32'h0);
      chk("rst_mid_done", 32'(done_a), 32'h0);
      chk("rst_mid_en", 32'(en_a), 32'h1);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (15) begin
         @(negedge clk);
         if (done_a) seen++;
      end
      chk("rst_no_done", 32'(seen), 32'd0);
      run(0, 1500, lat, bcnt);
      chk("out_1500", 32'(out_a), 32'h1500);

      run(1, 65535, lat, bcnt);
      chk("lat_65535", 32'(lat), 32'd16);
      chk("out_65535", 32'(out_b), 32'h65535);
      chk("en_65535", 32'(en_b), 32'h1F);
      for (int i = 0; i < 1000; i++) begin
         v = longint'($urandom_range(0, 65535));
         run(1, v, lat, bcnt);
         chk("rand_w16", 32'(out_b), to_bcd(v, 5));
      end

      run(2, 255, lat, bcnt);
      chk("out_undersized_255", 32'(out_c), 32'h55);
      chk("en_undersized_255", 32'(en_c), 32'h3);
      for (int i = 0; i < 200; i++) begin
         v = longint'($urandom_range(0, 255));
         run(2, v, lat, bcnt);
         chk("rand_w8", 32'(out_c), 32'(((v % 100) / 10) * 16 + (v % 10)));
      end

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
